mul_iter_sequencer: RTL and testbench

- Multi-cycle sequencer for the ALU multiply operation (ALU control code 3'b100).
- Sits beside the EX-stage ALU.
- When EX issues a MUL, it captures the operands and runs a radix-2 shift-add over WIDTH cycles, stalling the pipeline meanwhile.
- Presents the low WIDTH bits of the product with a one-cycle valid pulse.
- Replaces the single-cycle combinational multiply path so it leaves the critical path.

---
 rtl/mul_iter_sequencer.sv | 129 ++++++++++++
 tb/tb_mul_iter_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_iter_sequencer.sv
// mul_iter_sequencer
//   Multi-cycle radix-2 shift-add multiplier that sits beside the EX-stage ALU.
//   It starts when EX holds an instruction whose ALU control code is MUL_CODE.
//   It then captures both operands and stalls IF/ID/EX while it iterates.
//   When it finishes, it presents the low WIDTH bits of the product together
//   with a one-cycle valid pulse.
//
//   Ports:
//     clk_i       clock, all state on rising edge
//     rst_i       synchronous active-high reset
//     start_i     EX holds a valid instruction this cycle
//     alu_ctrl_i  ALU control code
//     data1_i     multiplicand
//     data2_i     multiplier
//     flush_i     abort any in-flight multiply
//     stall_o     hold IF/ID/EX (combinational)
//     busy_o      registered, high while iterating
//     valid_o     registered one-cycle pulse, result_o valid
//     result_o    low WIDTH bits of the product, held until the next completion
//
//   Build option:
//     MUL_EARLY_TERM_EN  finish as soon as no multiplier bits remain
//
//   state  | meaning
//   IDLE   | waiting for a MUL issue from EX
//   RUN    | one shift-add iteration per cycle, pipeline stalled
//   DONE   | result_o/valid_o presented for one cycle, pipeline released
module mul_iter_sequencer #(
    parameter int          WIDTH    = 32,
    parameter logic [2:0]  MUL_CODE = 3'b100,
    parameter int          CNT_W    = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       alu_ctrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             issue;
    logic             last_iter;
    logic [WIDTH-1:0] acc_sum;

    assign issue   = (state == S_IDLE) && start_i && (alu_ctrl_i == MUL_CODE) && !flush_i;
    assign acc_sum = mplier[0] ? (acc + mcand) : acc;

`ifdef MUL_EARLY_TERM_EN
    // Stop on the iteration that consumes the highest remaining multiplier
    // bit. Every later iteration would add zero, so the product is already final.
    assign last_iter = (cnt == CNT_W'(WIDTH - 1)) || ((mplier >> 1) == '0);
`else
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
`endif

    always_comb begin
        stall_o = issue || ((state == S_RUN) && !flush_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            busy_o   <= 1'b0;
            valid_o  <= 1'b0;
            result_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    valid_o <= 1'b0;
                    if (issue) begin
                        mcand  <= data1_i;
                        mplier <= data2_i;
                        acc    <= '0;
                        cnt    <= '0;
                        busy_o <= 1'b1;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (flush_i) begin
                        busy_o <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        acc    <= acc_sum;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + CNT_W'(1);
                        if (last_iter) begin
                            result_o <= acc_sum;
                            valid_o  <= 1'b1;
                            busy_o   <= 1'b0;
                            state    <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // The pulse is already out. A flush here does not cancel it,
                    // because the pipeline discards the result itself.
                    valid_o <= 1'b0;
                    state   <= S_IDLE;
                end
                default: begin
                    valid_o <= 1'b0;
                    busy_o  <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_iter_sequencer.sv
module tb_mul_iter_sequencer;

    localparam int WIDTH = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [2:0]        alu_ctrl;
    logic [WIDTH-1:0]  data1;
    logic [WIDTH-1:0]  data2;
    logic              flush;
    logic              stall;
    logic              busy;
    logic              valid;
    logic [WIDTH-1:0]  result;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] last_result = '0;

    mul_iter_sequencer #(.WIDTH(WIDTH), .MUL_CODE(3'b100), .CNT_W(6)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .alu_ctrl_i (alu_ctrl),
        .data1_i    (data1),
        .data2_i    (data2),
        .flush_i    (flush),
        .stall_o    (stall),
        .busy_o     (busy),
        .valid_o    (valid),
        .result_o   (result)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Number of RUN cycles the multiply of b should take.
    function automatic int exp_run(input logic [31:0] b);
`ifdef MUL_EARLY_TERM_EN
        int h;
        h = 0;
        for (int i = 0; i < WIDTH; i++)
            if (b[i]) h = i + 1;
        return (h < 1) ? 1 : h;
`else
        return WIDTH;
`endif
    endfunction

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b);
        int        run_len;
        int        n;
        bit        got;
        logic [63:0] full;
        logic [31:0] expv;
        run_len = exp_run(b);
        full    = 64'(a) * 64'(b);
        expv    = full[31:0];
        @(posedge clk); #1;
        start = 1'b1; alu_ctrl = 3'b100; data1 = a; data2 = b; flush = 1'b0;
        @(negedge clk);
        check_val("issue_stall", 32'(stall), 32'd1);
        check_val("issue_valid", 32'(valid), 32'd0);
        n = 0;
        got = 1'b0;
        while (!got && n < WIDTH + 5) begin
            @(posedge clk); #1;
            // Keep the inputs moving during RUN. The latched operands must be the only ones used.
            start = 1'($urandom_range(0, 1)); alu_ctrl = 3'($urandom);
            data1 = $urandom; data2 = $urandom;
            n++;
            @(negedge clk);
            if (valid) got = 1'b1;
            else if (n <= run_len) begin
                check_val("run_stall", 32'(stall), 32'd1);
                check_val("run_busy", 32'(busy), 32'd1);
            end
        end
        start = 1'b0;
        check_val("done_seen", 32'(got), 32'd1);
        check_val("latency", 32'(n), 32'(run_len + 1));
        check_val("result", result, expv);
        check_val("done_stall", 32'(stall), 32'd0);
        check_val("done_busy", 32'(busy), 32'd0);
        last_result = expv;
    endtask

    initial begin
        int fc;
        int vcount;
        rst = 1'b1; start = 1'b0; alu_ctrl = 3'b000; data1 = '0; data2 = '0; flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_stall", 32'(stall), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_valid", 32'(valid), 32'd0);
        check_val("rst_result", result, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_mul(32'd3, 32'd5);
        run_mul(32'hFFFF_FFFF, 32'd7);
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Codes other than MUL are ignored.
        @(posedge clk); #1;
        start = 1'b1; alu_ctrl = 3'b000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("nonmul_stall", 32'(stall), 32'd0);
            check_val("nonmul_valid", 32'(valid), 32'd0);
            check_val("nonmul_busy", 32'(busy), 32'd0);
            @(posedge clk); #1;
        end
        // A flush in the same cycle as an issue wins, and nothing is captured.
        alu_ctrl = 3'b100; flush = 1'b1;
        @(negedge clk);
        check_val("flushissue_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check_val("flushissue_busy", 32'(busy), 32'd0);

        // Back-to-back: the second issue lands in the cycle right after DONE.
        run_mul(32'd6, 32'd7);
        run_mul(32'd2, 32'd9);

        // A flush during RUN aborts the multiply.
        fc = (exp_run(32'h10) > 10) ? 10 : 2;
        @(posedge clk); #1;
        start = 1'b1; alu_ctrl = 3'b100; data1 = 32'h1234; data2 = 32'h10;
        @(negedge clk);
        for (int n = 1; n <= fc; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (n == fc) flush = 1'b1;
            @(negedge clk);
            if (n == fc) check_val("flush_stall", 32'(stall), 32'd0);
            else         check_val("preflush_stall", 32'(stall), 32'd1);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check_val("flush_busy", 32'(busy), 32'd0);
        check_val("flush_result_held", result, last_result);
        vcount = 0;
        for (int i = 0; i < WIDTH + 4; i++) begin
            if (valid) vcount++;
            @(negedge clk);
        end
        check_val("flush_no_valid", 32'(vcount), 32'd0);
        check_val("flush_stall_after", 32'(stall), 32'd0);

        // A reset in the middle of RUN returns the block to its reset values.
        @(posedge clk); #1;
        start = 1'b1; alu_ctrl = 3'b100; data1 = 32'h1234; data2 = 32'h8000_0000;
        for (int n = 1; n <= 5; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("midrst_busy", 32'(busy), 32'd0);
        check_val("midrst_valid", 32'(valid), 32'd0);
        check_val("midrst_result", result, 32'd0);
        check_val("midrst_stall", 32'(stall), 32'd0);
        last_result = '0;
        run_mul(32'd4, 32'd4);

        run_mul(32'd100, 32'd0);
        run_mul(32'd100, 32'h80);
        run_mul(32'd100, 32'd1);

        for (int i = 0; i < 20; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = $urandom;
            if (i % 3 == 0) b = b & 32'h0000_00FF;
            run_mul(a, b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
